// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: instruction fetch stage between the PC register and decode.
// It issues one request at a time to a variable-latency instruction memory
// and skid-buffers the returned word while decode is stalled. A flush kills
// whatever fetch is in flight or buffered. The IF/ID pipeline register is
// kept here, and FetchBusy asks the hazard unit to hold the PC until the
// current fetch retires into decode.
module fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        FetchBusy,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;       // PC of the request most recently issued
    logic [31:0] buf_q, buf_d;     // returned word parked while decode stalls
    logic        drop_q, drop_d;   // outstanding response must be discarded

    // IF/ID pipeline register
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    // Word handed to decode in the current cycle
    logic        load_en;
    logic [31:0] load_word;

    // FSM next state, memory request, busy flag and selection of the word for decode
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        pc_d      = pc_q;
        buf_d     = buf_q;
        drop_d    = drop_q;
        imem_req  = 1'b0;
        imem_addr = 32'h0000_0000;
        FetchBusy = 1'b1;
        load_en   = 1'b0;
        load_word = buf_q;

        unique case (state_q)
            IDLE: begin
                state_d = ISSUE;
            end

            ISSUE: begin
                // The response cannot arrive in the cycle the request is
                // issued, so imem_ready is not looked at here.
                imem_req  = 1'b1;
                imem_addr = PCF;
                pc_d      = PCF;
                if (FlushD) begin
                    drop_d = 1'b1;
                end
                state_d = WAIT;
            end

            WAIT: begin
                if (imem_ready) begin
                    if (drop_q || FlushD) begin
                        // Response belongs to a killed fetch: refetch from the redirected PC.
                        drop_d  = 1'b0;
                        state_d = ISSUE;
                    end else if (!StallD) begin
                        load_en   = 1'b1;
                        load_word = imem_rdata;
                        FetchBusy = 1'b0;
                        state_d   = ISSUE;
                    end else begin
                        buf_d   = imem_rdata;
                        state_d = HOLD;
                    end
                end else if (FlushD) begin
                    drop_d = 1'b1;
                end
            end

            HOLD: begin
                if (FlushD) begin
                    state_d = ISSUE;
                end else if (!StallD) begin
                    load_en   = 1'b1;
                    load_word = buf_q;
                    FetchBusy = 1'b0;
                    state_d   = ISSUE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // IF/ID next value: flush beats stall, which beats a new load; otherwise hold
    always_comb begin
        instr_d = instr_q;
        pcd_d   = pcd_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (FlushD) begin
            instr_d = NOP_INSTR;
            pcd_d   = 32'h0000_0000;
            pc4_d   = 32'h0000_0000;
            valid_d = 1'b0;
        end else if (!StallD && load_en) begin
            instr_d = load_word;
            pcd_d   = pc_q;
            pc4_d   = pc_q + 32'd4;   // wraps modulo 2^32
            valid_d = 1'b1;
        end
    end

    // FSM state and fetch bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= 32'h0000_0000;
            buf_q   <= 32'h0000_0000;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            drop_q  <= drop_d;
        end
    end

    // IF/ID pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'h0000_0000;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pc4_q;
    assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// tb_fetch_unit: directed cycle-exact scenarios followed by randomized
// traffic, checked every cycle against a transaction-level model of the
// fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] PCF = 32'h0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        FetchBusy;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;

    int n_tests = 0;
    int n_fail  = 0;
    bit run_cmp = 1'b0;

    fetch_unit #(.NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .reset      (reset),
        .PCF        (PCF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .FetchBusy  (FetchBusy),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level model: a request is either about to be issued,
    // outstanding (possibly killed), or its word is parked waiting for
    // decode. IF/ID follows the flush > stall > deliver rule.
    // ------------------------------------------------------------------
    logic        m_gap;      // one dead cycle after reset before the first issue
    logic        m_issue;    // a request goes out this cycle
    logic        m_pend;     // a request is outstanding
    logic [31:0] m_ppc;
    logic        m_pkill;
    logic        m_held;     // a returned word waits for decode
    logic [31:0] m_hword;
    logic [31:0] m_hpc;
    logic [31:0] m_instr, m_pcd, m_pc4;
    logic        m_valid;

    task automatic model_reset();
        m_gap   = 1'b1;
        m_issue = 1'b0;
        m_pend  = 1'b0;
        m_ppc   = 32'h0;
        m_pkill = 1'b0;
        m_held  = 1'b0;
        m_hword = 32'h0;
        m_hpc   = 32'h0;
        m_instr = NOP;
        m_pcd   = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
    endtask

    task automatic model_cycle();
        logic        dlv;
        logic [31:0] dw;
        logic [31:0] dp;
        logic        nxt_issue;
        dlv = 1'b0;
        dw  = 32'h0;
        dp  = 32'h0;
        nxt_issue = 1'b0;
        if (m_pend && imem_ready && !m_pkill && !FlushD && !StallD) begin
            dlv = 1'b1; dw = imem_rdata; dp = m_ppc;
        end
        if (m_held && !FlushD && !StallD) begin
            dlv = 1'b1; dw = m_hword; dp = m_hpc;
        end
        check("imem_req", {31'b0, imem_req}, {31'b0, m_issue});
        if (m_issue) check("imem_addr", imem_addr, PCF);
        check("FetchBusy", {31'b0, FetchBusy}, {31'b0, !dlv});

        if (m_gap) begin
            m_gap = 1'b0;
            nxt_issue = 1'b1;
        end else if (m_issue) begin
            m_pend  = 1'b1;
            m_ppc   = PCF;
            m_pkill = FlushD;
        end else if (m_pend) begin
            if (imem_ready) begin
                m_pend = 1'b0;
                if (m_pkill || FlushD || !StallD) begin
                    nxt_issue = 1'b1;
                end else begin
                    m_held  = 1'b1;
                    m_hword = imem_rdata;
                    m_hpc   = m_ppc;
                end
            end else if (FlushD) begin
                m_pkill = 1'b1;
            end
        end else if (m_held) begin
            if (FlushD || !StallD) begin
                m_held = 1'b0;
                nxt_issue = 1'b1;
            end
        end
        m_issue = nxt_issue;

        if (FlushD) begin
            m_instr = NOP; m_pcd = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!StallD && dlv) begin
            m_instr = dw; m_pcd = dp; m_pc4 = dp + 32'd4; m_valid = 1'b1;
        end
    endtask

    // Compare process: every cycle, mid-cycle, DUT against the model
    always @(negedge clk) begin
        if (run_cmp) begin
            if (reset) model_reset();
            check("InstrD",   InstrD,   m_instr);
            check("PCD",      PCD,      m_pcd);
            check("PCPlus4D", PCPlus4D, m_pc4);
            check("ValidD",   {31'b0, ValidD}, {31'b0, m_valid});
            if (reset) begin
                check("imem_req_rst",  {31'b0, imem_req},  {31'b0, m_issue});
                check("FetchBusy_rst", {31'b0, FetchBusy}, 32'd1);
            end else begin
                model_cycle();
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] pc4, input logic valid);
        check({tag, ".InstrD"},   InstrD,   instr);
        check({tag, ".PCD"},      PCD,      pc);
        check({tag, ".PCPlus4D"}, PCPlus4D, pc4);
        check({tag, ".ValidD"},   {31'b0, ValidD}, {31'b0, valid});
    endtask

    initial begin
        int          cd;
        logic [31:0] pc_next;
        run_cmp = 1'b1;
        repeat (2) @(posedge clk);

        // Cycle 0: reset released, IDLE
        next_cycle(); reset = 1'b0; PCF = 32'h0; #1;
        check_ifid("rst", NOP, 32'h0, 32'h0, 1'b0);
        check("rst.req",  {31'b0, imem_req},  32'd0);
        check("rst.busy", {31'b0, FetchBusy}, 32'd1);
        // Cycle 1: first ISSUE at PCF=0
        next_cycle(); #1;
        check("c1.req",  {31'b0, imem_req}, 32'd1);
        check("c1.addr", imem_addr, 32'h0);
        // Cycle 2: latency-1 response
        next_cycle(); imem_ready = 1'b1; imem_rdata = 32'h2008_0005; #1;
        check("c2.busy", {31'b0, FetchBusy}, 32'd0);
        // Cycle 3: IF/ID loaded, second ISSUE
        next_cycle(); imem_ready = 1'b0; PCF = 32'h40; #1;
        check_ifid("c3", 32'h2008_0005, 32'h0, 32'h4, 1'b1);
        check("c3.req",  {31'b0, imem_req}, 32'd1);
        check("c3.addr", imem_addr, 32'h40);
        check("c3.busy", {31'b0, FetchBusy}, 32'd1);
        // Cycles 4-5: waiting on a latency-3 response
        repeat (2) begin
            next_cycle(); #1;
            check("lat3.busy", {31'b0, FetchBusy}, 32'd1);
            check("lat3.req",  {31'b0, imem_req},  32'd0);
        end
        // Cycle 6: response
        next_cycle(); imem_ready = 1'b1; imem_rdata = 32'h0000_0013; #1;
        check("c6.busy", {31'b0, FetchBusy}, 32'd0);
        // Cycle 7: IF/ID updated four cycles after ISSUE
        next_cycle(); imem_ready = 1'b0; PCF = 32'h44; #1;
        check_ifid("c7", 32'h0000_0013, 32'h40, 32'h44, 1'b1);
        check("c7.addr", imem_addr, 32'h44);
        // Cycle 8: response while decode is stalled -> HOLD
        next_cycle(); imem_ready = 1'b1; imem_rdata = 32'hAC0A_0000; StallD = 1'b1; #1;
        check("c8.busy", {31'b0, FetchBusy}, 32'd1);
        // Cycles 9-10: stall held, no request, IF/ID unchanged
        repeat (2) begin
            next_cycle(); imem_ready = 1'b0; #1;
            check("hold.InstrD", InstrD, 32'h0000_0013);
            check("hold.req",  {31'b0, imem_req},  32'd0);
            check("hold.busy", {31'b0, FetchBusy}, 32'd1);
        end
        // Cycle 11: stall falls
        next_cycle(); StallD = 1'b0; #1;
        check("c11.busy", {31'b0, FetchBusy}, 32'd0);
        check("c11.InstrD", InstrD, 32'h0000_0013);
        // Cycle 12: buffered word visible, new ISSUE
        next_cycle(); PCF = 32'h48; #1;
        check_ifid("c12", 32'hAC0A_0000, 32'h44, 32'h48, 1'b1);
        check("c12.req", {31'b0, imem_req}, 32'd1);
        // Cycle 13: flush while waiting
        next_cycle(); FlushD = 1'b1; #1;
        // Cycle 14: redirect, IF/ID cleared
        next_cycle(); FlushD = 1'b0; PCF = 32'h100; #1;
        check_ifid("c14", NOP, 32'h0, 32'h0, 1'b0);
        // Cycle 15: stale response arrives and is dropped
        next_cycle(); imem_ready = 1'b1; imem_rdata = 32'h1234_5678; #1;
        check("c15.busy", {31'b0, FetchBusy}, 32'd1);
        // Cycle 16: refetch from redirected PC, stale data never loaded
        next_cycle(); imem_ready = 1'b0; #1;
        check("c16.req",  {31'b0, imem_req}, 32'd1);
        check("c16.addr", imem_addr, 32'h100);
        check_ifid("c16", NOP, 32'h0, 32'h0, 1'b0);
        // Cycle 17
        next_cycle(); imem_ready = 1'b1; imem_rdata = 32'h1111_1111; PCF = 32'hFFFF_FFFC; #1;
        // Cycle 18: top-of-memory fetch issued
        next_cycle(); imem_ready = 1'b0; #1;
        check_ifid("c18", 32'h1111_1111, 32'h100, 32'h104, 1'b1);
        check("c18.addr", imem_addr, 32'hFFFF_FFFC);
        // Cycle 19
        next_cycle(); imem_ready = 1'b1; imem_rdata = 32'h2222_2222; PCF = 32'h200; #1;
        // Cycle 20: PC+4 wraps to zero
        next_cycle(); imem_ready = 1'b0; #1;
        check_ifid("wrap", 32'h2222_2222, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
        check("c20.addr", imem_addr, 32'h200);
        // Cycle 21: reset in the middle of WAIT
        next_cycle(); reset = 1'b1; #1;
        check_ifid("midrst", NOP, 32'h0, 32'h0, 1'b0);
        check("midrst.req",  {31'b0, imem_req},  32'd0);
        check("midrst.busy", {31'b0, FetchBusy}, 32'd1);
        // Cycle 22: IDLE, late response arrives
        next_cycle(); reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; PCF = 32'h300; #1;
        check("c22.req", {31'b0, imem_req}, 32'd0);
        // Cycle 23: ISSUE at new PCF, late response still ignored
        next_cycle(); #1;
        check("c23.req",  {31'b0, imem_req}, 32'd1);
        check("c23.addr", imem_addr, 32'h300);
        check("c23.ValidD", {31'b0, ValidD}, 32'd0);
        // Cycle 24
        next_cycle(); imem_ready = 1'b0; #1;
        check_ifid("c24", NOP, 32'h0, 32'h0, 1'b0);
        // Cycle 25
        next_cycle(); imem_ready = 1'b1; imem_rdata = 32'h3333_3333; #1;
        // Cycle 26: first real post-reset fetch, new ISSUE
        next_cycle(); imem_ready = 1'b0; PCF = 32'h304; #1;
        check_ifid("c26", 32'h3333_3333, 32'h300, 32'h304, 1'b1);

        // Randomized traffic: memory with latency 1..4, PC register model
        cd = imem_req ? 1 : 0;
        pc_next = PCF;
        for (int c = 0; c < 4000; c++) begin
            next_cycle();
            imem_ready = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    imem_ready = 1'b1;
                    imem_rdata = $urandom;
                end
            end
            reset  = ($urandom_range(0, 599) == 0);
            FlushD = ($urandom_range(0, 15) == 0);
            StallD = ($urandom_range(0, 3) == 0);
            PCF    = pc_next;
            #1;
            if (imem_req) cd = int'($urandom_range(1, 4));
            if (FlushD)                       pc_next = $urandom & 32'hFFFF_FFFC;
            else if (!FetchBusy && !StallD)   pc_next = PCF + 32'd4;
            else                              pc_next = PCF;
        end

        reset = 1'b0; FlushD = 1'b0; StallD = 1'b0; imem_ready = 1'b0;
        repeat (2) next_cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
